// File: rtl/sha_padder.sv
// SHA message padder: packs big-endian 32-bit words into 512/1024-bit blocks,
// appends the 0x80 marker, zero fill and the bit-length field.
package sha;
  typedef enum logic [2:0] {
    SHA1   = 3'd0,
    SHA224 = 3'd1,
    SHA256 = 3'd2,
    SHA384 = 3'd3,
    SHA512 = 3'd4
  } mode_t;

  typedef union packed {
    logic [31:0][31:0] w32;
    logic [15:0][63:0] w64;
  } msg_t;
endpackage

module sha_padder (
  input  logic        clk,
  input  logic        rst,
  input  sha::mode_t  mode_i,
  input  logic [31:0] s_data_i,
  input  logic [2:0]  s_bytes_i,
  input  logic        s_last_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output sha::msg_t   m_block_o,
  output logic        m_last_o,
  output logic        m_valid_o,
  input  logic        m_ready_i
);

  typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

  state_t      state_q;
  sha::msg_t   block_q;
  logic [4:0]  idx_q;
  logic [60:0] bytes_q;
  logic        big_q;
  logic        first_q;
  logic        pend_q;
  logic        cont_pad_q;
  logic        valid_q;
  logic        last_q;

  logic        geo_big;
  logic [4:0]  last_slot;
  logic [4:0]  len_start;
  logic [63:0] len_bits;
  logic [31:0] in_word;

  function automatic logic [31:0] mark_word(input logic [31:0] d, input logic [2:0] b);
    case (b)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {d[31:24], 24'h80_0000};
      3'd2:    return {d[31:16], 16'h8000};
      3'd3:    return {d[31:8], 8'h80};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] keep_word(input logic [31:0] d, input logic [2:0] b);
    case (b)
      3'd0:    return 32'h0;
      3'd1:    return {d[31:24], 24'h0};
      3'd2:    return {d[31:16], 16'h0};
      3'd3:    return {d[31:8], 8'h0};
      default: return d;
    endcase
  endfunction

  // Geometry comes from mode_i only on the first word; afterwards it is frozen in big_q.
  always_comb begin
    geo_big   = big_q;
    if (state_q == FILL && first_q)
      geo_big = (mode_i == sha::SHA384) || (mode_i == sha::SHA512);
    last_slot = geo_big ? 5'd31 : 5'd15;
    len_start = geo_big ? 5'd28 : 5'd14;
    len_bits  = {bytes_q, 3'b000};
    in_word   = s_last_i ? mark_word(s_data_i, s_bytes_i) : keep_word(s_data_i, s_bytes_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      // NOTE: the block buffer is reset too, because m_block_o must read zero during reset.
      block_q    <= '0;
      idx_q      <= '0;
      bytes_q    <= '0;
      big_q      <= 1'b0;
      first_q    <= 1'b1;
      pend_q     <= 1'b0;
      cont_pad_q <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid_i) begin
            if (first_q) begin
              big_q   <= geo_big;
              first_q <= 1'b0;
            end
            block_q.w32[5'd31 - idx_q] <= in_word;
            bytes_q <= bytes_q + 61'(s_bytes_i);
            idx_q   <= idx_q + 5'd1;
            pend_q  <= s_last_i && (s_bytes_i == 3'd4);
            if (idx_q == last_slot) begin
              state_q    <= OUT;
              valid_q    <= 1'b1;
              last_q     <= 1'b0;
              cont_pad_q <= s_last_i;
            end else if (s_last_i) begin
              state_q <= PAD;
            end
          end
        end

        PAD: begin
          if (!pend_q && idx_q == len_start) begin
            // Upper half of the 128-bit field stays zero from the buffer clear.
            if (big_q) begin
              block_q.w32[1] <= len_bits[63:32];
              block_q.w32[0] <= len_bits[31:0];
            end else begin
              block_q.w32[17] <= len_bits[63:32];
              block_q.w32[16] <= len_bits[31:0];
            end
            state_q <= OUT;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
          end else begin
            block_q.w32[5'd31 - idx_q] <= pend_q ? 32'h8000_0000 : 32'h0;
            pend_q <= 1'b0;
            if (idx_q == last_slot) begin
              state_q    <= OUT;
              valid_q    <= 1'b1;
              last_q     <= 1'b0;
              cont_pad_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end

        OUT: begin
          if (m_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            block_q <= '0;
            idx_q   <= '0;
            if (last_q) begin
              state_q <= FILL;
              bytes_q <= '0;
              first_q <= 1'b1;
            end else begin
              state_q <= cont_pad_q ? PAD : FILL;
            end
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

  assign s_ready_o = !rst && (state_q == FILL);
  assign m_block_o = block_q;
  assign m_last_o  = last_q;
  assign m_valid_o = valid_q;

endmodule
